serial_mpy_param: RTL and testbench

Parametrised sequential shift-add multiplier: the next-generation serial multiplier for the datapath, generalised to any operand width `WIDTH`. It handles both signed (two's-complement) and unsigned operands via a per-operation mode bit. A start/busy/valid handshake replaces the free-running counter, so operations are issued on demand and may run back to back. The result register holds the last completed product stable between operations.

---
 rtl/serial_mpy_param.sv | 128 ++++++++++++
 tb/tb_serial_mpy_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mpy_param.sv
// Sequential shift-add multiplier, WIDTH-bit operands, signed or unsigned.
// One product per WIDTH+2 cycles; start/busy/valid handshake.
module serial_mpy_param #(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               busy,
    output logic [2*WIDTH-1:0] Product,
    output logic               Product_Valid
);

    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_P   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      LAST_IT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW-1:0]      acc;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      cnt;
    logic               sign_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [AW-1:0]      acc_sum;
    logic [AW-1:0]      acc_nxt;
    logic [2*WIDTH-1:0] acc_lo;
    logic [2*WIDTH-1:0] prod_nxt;
    logic               last_iter;

    // Operand magnitudes; -2^(WIDTH-1) wraps to 2^(WIDTH-1), read as unsigned.
    assign a_neg = signed_mode & in_a[WIDTH-1];
    assign b_neg = signed_mode & in_b[WIDTH-1];
    assign a_mag = a_neg ? (~in_a + ONE_W) : in_a;
    assign b_mag = b_neg ? (~in_b + ONE_W) : in_b;

    // The extra accumulator bit keeps the add carry before the shift.
    assign acc_sum = acc + {1'b0, mcand, {WIDTH{1'b0}}};
    assign acc_nxt = acc[0] ? (acc_sum >> 1) : (acc >> 1);

    assign acc_lo    = acc[2*WIDTH-1:0];
    assign prod_nxt  = sign_q ? (~acc_lo + ONE_P) : acc_lo;
    assign last_iter = (cnt == LAST_IT);

    assign busy = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc           <= '0;
            mcand         <= '0;
            cnt           <= '0;
            sign_q        <= 1'b0;
            Product       <= '0;
            Product_Valid <= 1'b0;
        end else begin
            Product_Valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= {1'b0, {WIDTH{1'b0}}, b_mag};
                        mcand  <= a_mag;
                        cnt    <= '0;
                        sign_q <= signed_mode & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    end
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + ONE_C;
                end
                S_FIX: begin
                    Product       <= prod_nxt;
                    Product_Valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mpy_param.sv
// Scoreboard bench for serial_mpy_param: WIDTH=8 and WIDTH=16 instances.
// Stimulus pushes expected products and due cycles; a monitor pops on valid.
module tb_serial_mpy_param;

    typedef struct {
        logic [31:0] prod;
        int          due;
    } exp_t;

    logic        CLK;
    logic        RST;

    logic        start8;
    logic        sm8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic [15:0] p8;
    logic        v8;

    logic        start16;
    logic        sm16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic [31:0] p16;
    logic        v16;

    int   cyc;
    logic rst_q;
    int   checks;
    int   errors;

    exp_t q8[$];
    exp_t q16[$];

    logic [15:0] last8;
    logic [31:0] last16;
    logic        pv8;
    logic        pv16;

    serial_mpy_param #(.WIDTH(8)) dut8 (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start8),
        .signed_mode   (sm8),
        .in_a          (a8),
        .in_b          (b8),
        .busy          (busy8),
        .Product       (p8),
        .Product_Valid (v8)
    );

    serial_mpy_param #(.WIDTH(16)) dut16 (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start16),
        .signed_mode   (sm16),
        .in_a          (a16),
        .in_b          (b16),
        .busy          (busy16),
        .Product       (p16),
        .Product_Valid (v16)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= RST;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic mon8();
        exp_t e;
        if (rst_q) begin
            q8.delete();
            check("rst8_product", {16'h0, p8}, 32'h0);
            check("rst8_valid", {31'h0, v8}, 32'h0);
            last8 = 16'h0;
            pv8   = 1'b0;
        end else begin
            if (v8) begin
                check("valid8_busy", {31'h0, busy8}, 32'h0);
                check("valid8_pulse", {31'h0, pv8}, 32'h0);
                if (q8.size() == 0) begin
                    check("valid8_unexpected", 32'h1, 32'h0);
                end else begin
                    e = q8.pop_front();
                    check("product8", {16'h0, p8}, e.prod);
                    check("latency8", cyc, e.due);
                end
                last8 = p8;
            end else begin
                check("stable8", {16'h0, p8}, {16'h0, last8});
            end
            pv8 = v8;
        end
    endtask

    task automatic mon16();
        exp_t e;
        if (rst_q) begin
            q16.delete();
            check("rst16_product", p16, 32'h0);
            check("rst16_valid", {31'h0, v16}, 32'h0);
            last16 = 32'h0;
            pv16   = 1'b0;
        end else begin
            if (v16) begin
                check("valid16_busy", {31'h0, busy16}, 32'h0);
                check("valid16_pulse", {31'h0, pv16}, 32'h0);
                if (q16.size() == 0) begin
                    check("valid16_unexpected", 32'h1, 32'h0);
                end else begin
                    e = q16.pop_front();
                    check("product16", p16, e.prod);
                    check("latency16", cyc, e.due);
                end
                last16 = p16;
            end else begin
                check("stable16", p16, last16);
            end
            pv16 = v16;
        end
    endtask

    // Called at a negedge; waits for IDLE, then presents operands for one edge.
    task automatic issue8(input logic sm, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp,
                          input bit hold);
        int n;
        n = 0;
        while (busy8 !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) check("issue8_timeout", 32'h1, 32'h0);
        sm8    = sm;
        a8     = a;
        b8     = b;
        start8 = 1'b1;
        q8.push_back('{{16'h0, exp}, cyc + 10});
        @(negedge CLK);
        if (!hold) start8 = 1'b0;
    endtask

    task automatic issue16(input logic sm, input logic [15:0] a,
                           input logic [15:0] b, input logic [31:0] exp);
        int n;
        n = 0;
        while (busy16 !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) check("issue16_timeout", 32'h1, 32'h0);
        sm16    = sm;
        a16     = a;
        b16     = b;
        start16 = 1'b1;
        q16.push_back('{exp, cyc + 18});
        @(negedge CLK);
        start16 = 1'b0;
    endtask

    initial begin
        int n;
        checks  = 0;
        errors  = 0;
        last8   = 16'h0;
        last16  = 32'h0;
        pv8     = 1'b0;
        pv16    = 1'b0;
        rst_q   = 1'b1;
        RST     = 1'b1;
        start8  = 1'b0;
        sm8     = 1'b0;
        a8      = 8'h0;
        b8      = 8'h0;
        start16 = 1'b0;
        sm16    = 1'b0;
        a16     = 16'h0;
        b16     = 16'h0;

        fork
            begin
                forever begin
                    @(negedge CLK);
                    mon8();
                    mon16();
                end
            end
            begin
                repeat (3) @(negedge CLK);
                RST = 1'b0;

                repeat (20) begin
                    @(negedge CLK);
                    check("idle_busy8", {31'h0, busy8}, 32'h0);
                    check("idle_busy16", {31'h0, busy16}, 32'h0);
                end

                issue8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);
                issue8(1'b1, 8'h80, 8'h7F, 16'hC080, 1'b0);
                issue8(1'b1, 8'h05, 8'hFD, 16'hFFF1, 1'b0);
                issue8(1'b1, 8'h00, 8'hFF, 16'h0000, 1'b0);
                issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);

                issue8(1'b0, 8'd12, 8'd13, 16'h009C, 1'b1);
                issue8(1'b1, 8'h07, 8'h07, 16'h0031, 1'b1);
                issue8(1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b1);
                issue8(1'b0, 8'd200, 8'd3, 16'h0258, 1'b1);
                issue8(1'b1, 8'h64, 8'h9C, 16'hD8F0, 1'b0);

                issue8(1'b0, 8'd10, 8'd10, 16'h0064, 1'b0);
                repeat (3) @(negedge CLK);
                sm8    = 1'b0;
                a8     = 8'd1;
                b8     = 8'd1;
                start8 = 1'b1;
                @(negedge CLK);
                start8 = 1'b0;

                issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
                repeat (3) @(negedge CLK);
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
                check("abort_busy8", {31'h0, busy8}, 32'h0);
                check("abort_product8", {16'h0, p8}, 32'h0);
                repeat (15) @(negedge CLK);

                issue8(1'b1, 8'hFE, 8'h03, 16'hFFFA, 1'b0);

                issue16(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000);
                issue16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);

                n = 0;
                while ((q8.size() != 0 || q16.size() != 0) && n < 300) begin
                    @(negedge CLK);
                    n++;
                end
                if (n >= 300) check("drain_timeout", 32'h1, 32'h0);
                repeat (5) @(negedge CLK);
            end
        join_any

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
